muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer beside the execute-stage ALU. Executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the architectural HI/LO registers.
- Raises a stall request so the pipeline holds any dependent instruction while an operation is in flight. Flush from the hazard logic aborts an in-flight operation.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  launch operation (held by the pipeline while stall_req is high).
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
- src_a  input  XLEN  rs operand (multiplicand / dividend).
- src_b  input  XLEN  rt operand (multiplier / divisor).
- hilo_rd  input  1  MFHI/MFLO in execute this cycle.
- hilo_wr  input  1  MTHI/MTLO write request.
- hilo_wr_sel  input  1  0=LO, 1=HI.
- hilo_wr_data  input  XLEN  MTHI/MTLO data.
- flush  input  1  abort in-flight operation.
- busy  output  1  operation in progress.
- stall_req  output  1  freeze the IF/ID/EX stages.
- done  output  1  one-cycle pulse; HI/LO updated this cycle.
- div_zero  output  1  one-cycle pulse, coincident with done, for a divide by zero.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done and div_zero = 0; hi and lo = 0; counter and internal registers = 0.
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Latch operand magnitudes. For signed ops: |x|, with 0x80000000 taken as unsigned 2^31.
  - Latch result sign flags: product sign = a31^b31; quotient sign = a31^b31; remainder sign = a31. Unsigned ops force all sign flags to 0.
  - Clear the counter and go to RUN.
  - Divide op with src_b==0: go directly to FIX with the dz flag set.
- RUN: one radix-2 step per cycle; counter increments each cycle.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract, giving quotient and remainder.
  - When counter == XLEN-1, go to FIX. RUN therefore lasts exactly XLEN cycles.
- FIX (1 cycle): apply two's-complement sign correction, write results, pulse done, return to IDLE.
  - Multiply: hi = upper product half, lo = lower product half.
  - Divide: lo = quotient, hi = remainder.
  - dz set: lo = all ones, hi = src_a as latched (raw, not magnitude); div_zero=1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF) naturally yields lo=0x80000000, hi=0. No special case is needed.
- Latency:
  - Normal operation: start accepted at edge N; done high in cycle N+XLEN+1 (33 cycles at XLEN=32); hi/lo valid from edge N+XLEN+1.
  - Divide by zero: done in cycle N+1.
- busy = (state != IDLE).
- stall_req = busy & (start | hilo_rd | hilo_wr). An independent instruction proceeds without stalling.
- start while busy: ignored (no restart); the pipeline keeps it held via stall_req.
- hilo_wr:
  - In IDLE: written at the edge.
  - While busy: ignored, and the stall holds it.
  - In IDLE with start=1 in the same cycle: both take effect; the sequence result later overwrites hi/lo.
- flush=1:
  - In any state: next state is IDLE; hi/lo unchanged; no done pulse. Flush has priority over start and over FIX.
  - Flush in IDLE together with start: start is not accepted.
- done and div_zero are never asserted outside FIX.
- Reset mid-operation: all state cleared immediately, including hi/lo.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> done at 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT 0xFFFFFFFD × 7 (−3×7) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> done and div_zero pulse one cycle after start; lo=0xFFFFFFFF, hi=100. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO 0x1234 in IDLE -> lo=0x1234 next edge. While busy: hilo_rd=1 or hilo_wr=1 -> stall_req=1, lo not changed until done; second start while busy ignored.
- DIVU 50/7 started, flush at cycle 10 -> busy drops next edge; hi/lo retain prior values; no done pulse; a new start is then accepted normally and yields lo=7, hi=1.
- Reset asserted at cycle 15 of a MULT -> busy, hi, lo and done go to 0 immediately (asynchronously); after release, state is IDLE with stall_req=0.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer that owns the architectural HI/LO registers.
// It runs one radix-2 step per cycle and stalls dependent instructions while busy.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            hilo_rd,
  input  logic            hilo_wr,
  input  logic            hilo_wr_sel,
  input  logic [XLEN-1:0] hilo_wr_data,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc;
  logic              is_div, sgn_q, sgn_r, dz;

  logic              accept, op_div, op_signed, b_zero, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     mul_sum, div_part, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    op_div    = op[1];
    op_signed = ~op[0];
    b_zero    = (src_b == '0);
    a_neg     = op_signed & src_a[XLEN-1];
    b_neg     = op_signed & src_b[XLEN-1];
    a_abs     = a_neg ? ('0 - src_a) : src_a;
    b_abs     = b_neg ? ('0 - src_b) : src_b;
    accept    = (state == IDLE) & start & ~flush;
  end

  // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
  // Divide: acc holds {remainder, dividend/quotient}; shift left and try-subtract the divisor.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_a : '0)};
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_part = acc[2*XLEN-1:XLEN-1];
    div_diff = div_part - {1'b0, mag_b};
    if (!div_diff[XLEN])
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      div_next = {div_part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  always_comb begin
    prod = sgn_q ? ('0 - acc) : acc;
    quo  = sgn_q ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem  = sgn_r ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    stall_req = busy & (start | hilo_rd | hilo_wr);
    done      = (state == FIX) & ~flush;
    div_zero  = done & dz;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_nxt = (op_div && b_zero) ? FIX : RUN;
        RUN:  if (cnt == CNT_W'(XLEN - 1)) state_nxt = FIX;
        FIX:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      sgn_q  <= 1'b0;
      sgn_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (accept) begin
        // A divide by zero never runs, so mag_a carries the raw dividend for HI.
        mag_a  <= (op_div && b_zero) ? src_a : a_abs;
        mag_b  <= b_abs;
        is_div <= op_div;
        sgn_q  <= a_neg ^ b_neg;
        sgn_r  <= a_neg;
        dz     <= op_div & b_zero;
        cnt    <= '0;
        acc    <= op_div ? {{XLEN{1'b0}}, a_abs} : {{XLEN{1'b0}}, b_abs};
      end else if (state == RUN && !flush) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? div_next : mul_next;
      end

      if (state == IDLE && hilo_wr) begin
        if (hilo_wr_sel) hi <= hilo_wr_data;
        else             lo <= hilo_wr_data;
      end else if (done) begin
        if (dz) begin
          hi <= mag_a;
          lo <= '1;
        end else if (is_div) begin
          hi <= rem;
          lo <= quo;
        end else begin
          hi <= prod[2*XLEN-1:XLEN];
          lo <= prod[XLEN-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes arithmetic-model results,
// a monitor pops and compares on every done pulse.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] src_a = '0, src_b = '0, hilo_wr_data = '0;
  logic        hilo_rd = 1'b0, hilo_wr = 1'b0, hilo_wr_sel = 1'b0, flush = 1'b0;
  logic        busy, stall_req, done, div_zero;
  logic [31:0] hi, lo;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hilo_rd(hilo_rd), .hilo_wr(hilo_wr), .hilo_wr_sel(hilo_wr_sel),
    .hilo_wr_data(hilo_wr_data), .flush(flush), .busy(busy), .stall_req(stall_req),
    .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned issue;
    int unsigned lat;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference results from plain 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0; e.lat = 32; e.issue = 0; e.hi = '0; e.lo = '0;
    case (o)
      2'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin u = {32'd0, a} * {32'd0, b}; e.hi = u[63:32]; e.lo = u[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.dz = 1'b1; e.lat = 0; e.hi = a; e.lo = 32'hFFFF_FFFF;
        end else if (o == 2'd2) begin
          p = sa / sb; e.lo = p[31:0];
          p = sa % sb; e.hi = p[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (div_zero === 1'b1 && done !== 1'b1) check("div_zero_without_done", div_zero, 0);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = sb_q.pop_front();
          check("div_zero", div_zero, e.dz);
          check("latency", cyc - e.issue, e.lat);
          @(posedge clk); #1;
          check("hi", hi, e.hi);
          check("lo", lo, e.lo);
        end
      end
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    if (busy) check("idle_timeout", busy, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    start = 1'b1; op = o; src_a = a; src_b = b;
    e = model(o, a, b);
    @(posedge clk); #1;
    e.issue = cyc;
    sb_q.push_back(e);
    start = 1'b0;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    logic [31:0] hi_prev, lo_prev;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b1;
    @(negedge clk);

    // MTLO / MTHI in IDLE
    hilo_wr = 1'b1; hilo_wr_sel = 1'b0; hilo_wr_data = 32'h1234;
    @(posedge clk); #1;
    check("mtlo", lo, 32'h1234);
    hilo_wr_sel = 1'b1; hilo_wr_data = 32'hABCD;
    @(posedge clk); #1;
    check("mthi", hi, 32'hABCD);
    hilo_wr = 1'b0;

    // MULTU max operands; busy spans RUN plus FIX
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bc = 0;
    for (int i = 0; i < 100 && busy; i++) begin @(posedge clk); #1; bc++; end
    check("busy_cycles", bc, 33);

    issue(2'd0, 32'hFFFF_FFFD, 32'd7);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    issue(2'd3, 32'd100, 32'd0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    drain();

    // Stalls and ignored requests while busy
    issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    check("no_stall_independent", stall_req, 0);
    hilo_rd = 1'b1; #1;
    check("stall_hilo_rd", stall_req, 1);
    hilo_rd = 1'b0; hilo_wr = 1'b1; hilo_wr_sel = 1'b0; hilo_wr_data = 32'hDEAD; #1;
    check("stall_hilo_wr", stall_req, 1);
    lo_prev = lo;
    @(posedge clk); #1;
    check("busy_mtlo_ignored", lo, lo_prev);
    @(negedge clk);
    hilo_wr = 1'b0;
    start = 1'b1; op = 2'd3; src_a = 32'd5; src_b = 32'd0; #1;
    check("stall_start", stall_req, 1);
    @(negedge clk);
    start = 1'b0;
    drain();

    // MTHI together with start: write lands now, result overwrites later
    hilo_wr = 1'b1; hilo_wr_sel = 1'b1; hilo_wr_data = 32'h5555;
    issue(2'd1, 32'd3, 32'd5);
    check("mthi_with_start", hi, 32'h5555);
    hilo_wr = 1'b0;
    drain();

    // Flush mid-divide: no done, HI/LO untouched, then a clean restart
    hi_prev = hi; lo_prev = lo;
    wait_idle();
    start = 1'b1; op = 2'd3; src_a = 32'd50; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_busy", busy, 0);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    check("flush_hi", hi, hi_prev);
    check("flush_lo", lo, lo_prev);
    issue(2'd3, 32'd50, 32'd7);
    drain();

    // Flush in IDLE blocks start
    wait_idle();
    flush = 1'b1; start = 1'b1; op = 2'd1; src_a = 32'd2; src_b = 32'd2;
    @(posedge clk); #1;
    check("flush_blocks_start", busy, 0);
    flush = 1'b0; start = 1'b0;

    for (int n = 0; n < 40; n++) begin
      logic [1:0] o;
      o = 2'($urandom_range(0, 3));
      issue(o, rnd_operand(), rnd_operand());
    end
    drain();

    // Asynchronous reset in the middle of a MULT
    wait_idle();
    hilo_wr = 1'b1; hilo_wr_sel = 1'b0; hilo_wr_data = 32'h77;
    @(posedge clk); #1;
    hilo_wr_sel = 1'b1; hilo_wr_data = 32'h88;
    @(posedge clk); #1;
    hilo_wr = 1'b0;
    start = 1'b1; op = 2'd0; src_a = 32'hFFFF_FFFB; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); #2;
    check("pre_reset_busy", busy, 1);
    reset = 1'b0; #1;
    check("areset_busy", busy, 0);
    check("areset_done", done, 0);
    check("areset_hi", hi, 0);
    check("areset_lo", lo, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    hilo_rd = 1'b1; #1;
    check("post_reset_busy", busy, 0);
    check("post_reset_stall", stall_req, 0);
    hilo_rd = 1'b0;

    issue(2'd0, 32'h8000_0000, 32'h8000_0000);
    issue(2'd2, 32'd7, 32'hFFFF_FFFE);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
